tdc_hist_stat: RTL and testbench
================================

# tdc_hist_stat

Windowed statistics accumulator for the TDC Hamming-weight stream. Sits downstream of the pop-count stage in the `clk_capture` domain. After a start pulse it discards a programmable number of pipeline-flush samples. It then accumulates sum, minimum and maximum of the `hw` stream over a programmed sample count, and presents the result on a valid/ready port. Firmware or the scan-out logic reads an averaged delay-line code without capturing every sample.

## Interface
- `N`, 64: delay-line length; largest legal `hw` value.
- `HW_W`, `$clog2(N)+1`: width of `hw_in`.
- `CNT_W`, 8: width of `n_samples`. Window is 1..2^CNT_W samples.
- `DISCARD`, 2: `en`-qualified samples dropped after start (sync + pop-count flush). May be 0.
- `SUM_W`, `HW_W+CNT_W`: sum width. Overflow is impossible at this width.

Ports:
- `clk_capture`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: sample qualifier, same `en` that gates the capture/pop-count chain.
- `hw_in`, in, `HW_W`: Hamming weight from the pop-count stage.
- `start`, in, 1: begin a window. Honoured only in IDLE.
- `n_samples`, in, `CNT_W`: window length. 0 means 2^CNT_W. Latched on accepted start.
- `busy`, out, 1: high in FLUSH and ACCUM.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: consumer accepts result.
- `res_sum`, out, `SUM_W`: sum of accumulated samples.
- `res_min`, out, `HW_W`: minimum accumulated sample.
- `res_max`, out, `HW_W`: maximum accumulated sample.
- `res_cnt`, out, `CNT_W+1`: samples accumulated (1..2^CNT_W).
- `res_oor`, out, 1: at least one accumulated sample had `hw_in > N`.

## Operation
- FSM states: IDLE, FLUSH, ACCUM, HOLD. Reset state is IDLE.
- Reset values: `busy=0`, `res_valid=0`, `res_sum=0`, `res_min=0`, `res_max=0`, `res_cnt=0`, `res_oor=0`. All internal counters and the latched length are cleared.
- **IDLE**
  - `start=1` latches `n_samples`. Zero is mapped to 2^CNT_W.
  - Accumulators are cleared and the flush counter is loaded with `DISCARD`.
  - Next state is FLUSH, or ACCUM if `DISCARD=0`. `en` is not required to accept start.
- **FLUSH**
  - Each `en=1` cycle decrements the flush counter; `hw_in` is ignored.
  - The cycle that consumes the last discard sample transitions to ACCUM.
- **ACCUM**
  - Each `en=1` cycle: `sum += hw_in`, `cnt += 1`, `oor |= (hw_in > N)`.
  - The first sample loads min and max directly; later samples update them with min()/max().
  - When `cnt` reaches the latched length, the result registers load and the state moves to HOLD.
- **HOLD**
  - `res_valid=1`; all `res_*` outputs are held stable.
  - `res_valid && res_ready` returns to IDLE, with `res_valid=0` the next cycle.
  - `en` and `start` are ignored.
- `en=0` freezes FLUSH and ACCUM completely: no counter moves and no sample is taken.
- `start` outside IDLE is ignored, with no effect and no queueing.
- A start asserted in the same cycle as the HOLD handshake is ignored. The FSM is in HOLD that cycle.
- `res_*` outputs keep their last result in IDLE, FLUSH and ACCUM. They change only on the HOLD entry edge or on reset.
- `rst` mid-window aborts immediately to the reset state. No partial result is presented.
- All arithmetic is unsigned. min/max use unsigned compare on the full `HW_W` bits, including out-of-range values.

## Timing
- The start edge at cycle t gives `busy=1` from t+1.
- With `en` held high, window length S and DISCARD=D:
  - samples are taken at edges t+D+1 … t+D+S;
  - `res_valid=1` and `busy=0` from t+D+S+1.
- Each `en=0` cycle during FLUSH or ACCUM delays completion by exactly one cycle.
- The sample used is the `hw_in` value present at the clock edge. There is no input pipeline.
- Result-to-IDLE takes 1 cycle after the handshake. The earliest next start is on the cycle after `res_valid` falls.

## Test plan
- **Basic window.** D=2, S=4, en=1. `hw_in` sequence 9,9 (discarded), then 10,12,8,14. Expect sum=44, min=8, max=14, cnt=4, oor=0. `res_valid` rises 7 cycles after the start edge.
- **Zero length.** `n_samples=0`, constant `hw_in=64`, D=0. Expect cnt=256, sum=16384, min=max=64, after 256 sampling cycles.
- **en gating.** S=3 with `en` toggling 1,0,1,0,1 during ACCUM. Samples are taken only on `en` cycles, the result is correct, and completion is delayed by 2 cycles.
- **Backpressure and ignored start.** Hold `res_ready=0` for 10 cycles. Outputs stay stable and `res_valid` stays high. Pulses of `start` during busy and during HOLD have no effect. `res_ready=1` drops `res_valid` the next cycle.
- **Out of range.** Inject `hw_in=65` (N=64) in a window. Expect `res_oor=1` and `res_max=65`. The next window with legal data gives `res_oor=0`.
- **Reset mid-window.** Assert `rst` for one cycle mid-ACCUM. All outputs read 0 and the FSM is in IDLE. A new start gives a correct result unaffected by earlier samples.

Source files
------------

// File: rtl/tdc_hist_stat.sv
// Windowed sum/min/max accumulator for the TDC Hamming-weight stream.
// Discards DISCARD flush samples after start, accumulates a window and holds the result.
module tdc_hist_stat #(
    parameter int unsigned N       = 64,
    parameter int unsigned HW_W    = $clog2(N) + 1,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DISCARD = 2,
    parameter int unsigned SUM_W   = HW_W + CNT_W
) (
    input  logic               clk_capture,
    input  logic               rst,
    input  logic               en,
    input  logic [HW_W-1:0]    hw_in,
    input  logic               start,
    input  logic [CNT_W-1:0]   n_samples,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SUM_W-1:0]   res_sum,
    output logic [HW_W-1:0]    res_min,
    output logic [HW_W-1:0]    res_max,
    output logic [CNT_W:0]     res_cnt,
    output logic               res_oor
);

    localparam int unsigned FL_W = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [FL_W-1:0]  flush_q, flush_d;
    logic [CNT_W:0]   len_q, len_d;
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [HW_W-1:0]  min_q, min_d;
    logic [HW_W-1:0]  max_q, max_d;
    logic             oor_q, oor_d;

    logic [SUM_W-1:0] res_sum_q, res_sum_d;
    logic [HW_W-1:0]  res_min_q, res_min_d;
    logic [HW_W-1:0]  res_max_q, res_max_d;
    logic [CNT_W:0]   res_cnt_q, res_cnt_d;
    logic             res_oor_q, res_oor_d;

    logic [SUM_W-1:0] sum_nx;
    logic [CNT_W:0]   cnt_nx;
    logic [HW_W-1:0]  min_nx;
    logic [HW_W-1:0]  max_nx;
    logic             oor_nx;

    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        min_d     = min_q;
        max_d     = max_q;
        oor_d     = oor_q;
        res_sum_d = res_sum_q;
        res_min_d = res_min_q;
        res_max_d = res_max_q;
        res_cnt_d = res_cnt_q;
        res_oor_d = res_oor_q;

        // First sample of a window seeds min/max regardless of their cleared value.
        sum_nx = sum_q + SUM_W'(hw_in);
        cnt_nx = cnt_q + (CNT_W+1)'(1);
        min_nx = (cnt_q == '0 || hw_in < min_q) ? hw_in : min_q;
        max_nx = (cnt_q == '0 || hw_in > max_q) ? hw_in : max_q;
        oor_nx = oor_q | (hw_in > HW_W'(N));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = (n_samples == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, n_samples};
                    cnt_d   = '0;
                    sum_d   = '0;
                    min_d   = '0;
                    max_d   = '0;
                    oor_d   = 1'b0;
                    flush_d = FL_W'(DISCARD);
                    state_d = (DISCARD == 0) ? ST_ACCUM : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (en) begin
                    flush_d = flush_q - FL_W'(1);
                    if (flush_q == FL_W'(1)) begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (en) begin
                    sum_d = sum_nx;
                    cnt_d = cnt_nx;
                    min_d = min_nx;
                    max_d = max_nx;
                    oor_d = oor_nx;
                    if (cnt_nx == len_q) begin
                        res_sum_d = sum_nx;
                        res_min_d = min_nx;
                        res_max_d = max_nx;
                        res_cnt_d = cnt_nx;
                        res_oor_d = oor_nx;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_capture) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            flush_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            oor_q     <= 1'b0;
            res_sum_q <= '0;
            res_min_q <= '0;
            res_max_q <= '0;
            res_cnt_q <= '0;
            res_oor_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            min_q     <= min_d;
            max_q     <= max_d;
            oor_q     <= oor_d;
            res_sum_q <= res_sum_d;
            res_min_q <= res_min_d;
            res_max_q <= res_max_d;
            res_cnt_q <= res_cnt_d;
            res_oor_q <= res_oor_d;
        end
    end

    assign busy      = (state_q == ST_FLUSH) || (state_q == ST_ACCUM);
    assign res_valid = (state_q == ST_HOLD);
    assign res_sum   = res_sum_q;
    assign res_min   = res_min_q;
    assign res_max   = res_max_q;
    assign res_cnt   = res_cnt_q;
    assign res_oor   = res_oor_q;

endmodule

// File: tb/tb_tdc_hist_stat.sv
// Directed bench for tdc_hist_stat: a DISCARD=2 instance driven from a vector table
// plus hand sequences, and a DISCARD=0 instance for the full-length window.
module tb_tdc_hist_stat;

    localparam int unsigned N     = 64;
    localparam int unsigned HW_W  = 7;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SUM_W = 15;
    localparam int          NSEQ  = 10;

    logic             clk_capture = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [HW_W-1:0]  hw_in = '0;
    logic             start = 1'b0;
    logic             start_z = 1'b0;
    logic [CNT_W-1:0] n_samples = '0;
    logic             res_ready = 1'b0;

    logic             busy, res_valid, res_oor;
    logic [SUM_W-1:0] res_sum;
    logic [HW_W-1:0]  res_min, res_max;
    logic [CNT_W:0]   res_cnt;

    logic             busy_z, res_valid_z, res_oor_z;
    logic [SUM_W-1:0] res_sum_z;
    logic [HW_W-1:0]  res_min_z, res_max_z;
    logic [CNT_W:0]   res_cnt_z;

    int checks = 0;
    int errors = 0;

    always #5 clk_capture = ~clk_capture;

    tdc_hist_stat #(.N(N), .CNT_W(CNT_W), .DISCARD(2)) u_dut (
        .clk_capture(clk_capture), .rst(rst), .en(en), .hw_in(hw_in), .start(start),
        .n_samples(n_samples), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_min(res_min), .res_max(res_max), .res_cnt(res_cnt),
        .res_oor(res_oor)
    );

    tdc_hist_stat #(.N(N), .CNT_W(CNT_W), .DISCARD(0)) u_dut_z (
        .clk_capture(clk_capture), .rst(rst), .en(en), .hw_in(hw_in), .start(start_z),
        .n_samples(n_samples), .busy(busy_z), .res_valid(res_valid_z),
        .res_ready(res_ready), .res_sum(res_sum_z), .res_min(res_min_z),
        .res_max(res_max_z), .res_cnt(res_cnt_z), .res_oor(res_oor_z)
    );

    typedef struct {
        string name;
        int    n;
        int    en_seq[NSEQ];
        int    hw_seq[NSEQ];
        int    sum, mn, mx, cnt, oor, lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_capture);
        @(negedge clk_capture);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic apply_vec(input vec_t v);
        int lat;
        start     = 1'b1;
        n_samples = CNT_W'(v.n);
        en        = 1'b0;
        step();
        start = 1'b0;
        chk({v.name, " busy"}, busy, 1);
        lat = 1;
        for (int k = 0; k < 300; k++) begin
            en    = (k < NSEQ) ? (v.en_seq[k] != 0) : 1'b1;
            hw_in = (k < NSEQ) ? HW_W'(v.hw_seq[k]) : '0;
            step();
            lat++;
            if (res_valid) break;
        end
        chk({v.name, " lat"}, lat, v.lat);
        chk({v.name, " busy_done"}, busy, 0);
        chk({v.name, " sum"}, res_sum, v.sum);
        chk({v.name, " min"}, res_min, v.mn);
        chk({v.name, " max"}, res_max, v.mx);
        chk({v.name, " cnt"}, res_cnt, v.cnt);
        chk({v.name, " oor"}, res_oor, v.oor);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({v.name, " valid_drop"}, res_valid, 0);
        chk({v.name, " sum_kept"}, res_sum, v.sum);
    endtask

    task automatic set_vec(input int i, input string name, input int n,
                           input int en_seq[NSEQ], input int hw_seq[NSEQ],
                           input int sum, input int mn, input int mx, input int cnt,
                           input int oor, input int lat);
        vecs[i].name   = name;
        vecs[i].n      = n;
        vecs[i].en_seq = en_seq;
        vecs[i].hw_seq = hw_seq;
        vecs[i].sum    = sum;
        vecs[i].mn     = mn;
        vecs[i].mx     = mx;
        vecs[i].cnt    = cnt;
        vecs[i].oor    = oor;
        vecs[i].lat    = lat;
    endtask

    initial begin
        int lat;

        // Latency counts cycles from the start edge to the first cycle res_valid is high.
        set_vec(0, "basic", 4, '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1},
                '{9, 9, 10, 12, 8, 14, 0, 0, 0, 0}, 44, 8, 14, 4, 0, 7);
        set_vec(1, "en_gate", 3, '{1, 1, 1, 0, 1, 0, 1, 1, 1, 1},
                '{50, 50, 20, 99, 5, 77, 33, 0, 0, 0}, 58, 5, 33, 3, 0, 8);
        set_vec(2, "oor", 3, '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1},
                '{1, 1, 65, 3, 64, 0, 0, 0, 0, 0}, 132, 3, 65, 3, 1, 6);
        set_vec(3, "legal_after_oor", 2, '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1},
                '{0, 0, 0, 64, 0, 0, 0, 0, 0, 0}, 64, 0, 64, 2, 0, 5);
        set_vec(4, "single", 1, '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1},
                '{7, 7, 63, 0, 0, 0, 0, 0, 0, 0}, 63, 63, 63, 1, 0, 4);
        set_vec(5, "flush_gate", 2, '{1, 0, 1, 1, 1, 1, 1, 1, 1, 1},
                '{100, 100, 100, 2, 3, 0, 0, 0, 0, 0}, 5, 2, 3, 2, 0, 6);
        set_vec(6, "max_code", 2, '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1},
                '{5, 5, 127, 0, 0, 0, 0, 0, 0, 0}, 127, 0, 127, 2, 1, 5);

        @(negedge clk_capture);
        step();
        rst = 1'b0;
        chk("rst busy", busy, 0);
        chk("rst valid", res_valid, 0);
        chk("rst sum", res_sum, 0);
        chk("rst min", res_min, 0);
        chk("rst max", res_max, 0);
        chk("rst cnt", res_cnt, 0);
        chk("rst oor", res_oor, 0);

        for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

        // Start pulses while busy and in HOLD, plus backpressure.
        start = 1'b1; n_samples = 8'd4; en = 1'b0;
        step();
        start = 1'b0; en = 1'b1; hw_in = 7'd10;
        lat = 1;
        step(); lat++;
        start = 1'b1; n_samples = 8'd1;
        step(); lat++;
        start = 1'b0;
        for (int k = 0; k < 20 && !res_valid; k++) begin
            step(); lat++;
        end
        chk("bp lat", lat, 7);
        chk("bp cnt", res_cnt, 4);
        chk("bp sum", res_sum, 40);
        for (int k = 0; k < 10; k++) begin
            start = k[0]; hw_in = 7'd99;
            step();
            chk("bp hold valid", res_valid, 1);
            chk("bp hold sum", res_sum, 40);
        end
        chk("bp hold cnt", res_cnt, 4);
        chk("bp hold max", res_max, 10);
        res_ready = 1'b1; start = 1'b1;
        step();
        res_ready = 1'b0; start = 1'b0;
        chk("bp valid_drop", res_valid, 0);
        chk("bp start_in_hs busy", busy, 0);
        step();
        chk("bp still idle", busy, 0);

        // Zero length on the DISCARD=0 instance.
        start_z = 1'b1; n_samples = 8'd0; en = 1'b1; hw_in = 7'd64;
        step();
        start_z = 1'b0;
        chk("zl busy", busy_z, 1);
        lat = 1;
        for (int k = 0; k < 400 && !res_valid_z; k++) begin
            step(); lat++;
        end
        chk("zl lat", lat, 257);
        chk("zl cnt", res_cnt_z, 256);
        chk("zl sum", res_sum_z, 16384);
        chk("zl min", res_min_z, 64);
        chk("zl max", res_max_z, 64);
        chk("zl oor", res_oor_z, 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("zl valid_drop", res_valid_z, 0);

        // Reset mid-ACCUM discards the partial window and clears the held result.
        start = 1'b1; n_samples = 8'd4; en = 1'b1; hw_in = 7'd60;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid rst busy", busy, 0);
        chk("mid rst valid", res_valid, 0);
        chk("mid rst sum", res_sum, 0);
        chk("mid rst min", res_min, 0);
        chk("mid rst max", res_max, 0);
        chk("mid rst cnt", res_cnt, 0);
        chk("mid rst oor", res_oor, 0);
        step();
        chk("mid idle", busy, 0);
        apply_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
